// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared types and constants for the LED index sequencer.
package led_seq_pkg;
   localparam int IDX_W = 4;
   localparam logic [IDX_W-1:0] IDX_MAX = 4'd15;
   typedef enum logic [1:0] {MODE_MANUAL = 2'b00, MODE_UP, MODE_DOWN, MODE_PINGPONG} mode_t;
   typedef enum logic [1:0] {ST_OFF, ST_MANUAL, ST_SCAN} state_t;
endpackage

// File: rtl/debounce_vec.sv
// debounce_vec: synchronises a raw switch vector and releases it after DB_CYCLES stable cycles.
module debounce_vec #(
   parameter int WIDTH     = 7,
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] db
);
   localparam int CW = $clog2(DB_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
   logic [WIDTH-1:0] s1_q, s2_q, s3_q, db_q, db_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   // one counter serves the whole vector: any bit moving restarts the window
   always_comb begin
      cnt_d = (s2_q != s3_q) ? '0 : (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      db_d  = (s2_q == s3_q && cnt_q == CNT_MAX) ? s2_q : db_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q  <= '0;
         s2_q  <= '0;
         s3_q  <= '0;
         db_q  <= '0;
         cnt_q <= '0;
      end else begin
         s1_q  <= din;
         s2_q  <= s1_q;
         s3_q  <= s2_q;
         db_q  <= db_d;
         cnt_q <= cnt_d;
      end
   end
   assign db = db_q;
endmodule

// File: rtl/led_index_sequencer.sv
// led_index_sequencer: debounced switches to LED index/enable, with manual,
// up, down and ping-pong scan modes stepped by a prescaler.
module led_index_sequencer
   import led_seq_pkg::*;
#(
   parameter int DB_CYCLES   = 1_000_000,
   parameter int STEP_CYCLES = 25_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] sw,
   input  logic       en,
   input  logic [1:0] mode,
   output logic [3:0] idx,
   output logic       idx_en,
   output logic       tick
);
   localparam int PW = $clog2(STEP_CYCLES);
   localparam logic [PW-1:0] PRE_MAX = PW'(STEP_CYCLES - 1);
   logic [6:0]       db;
   mode_t            db_mode;
   state_t           st;
   logic             chg, step, pp_dir;
   logic [IDX_W-1:0] idx_q, idx_d, scan_idx;
   logic             idx_en_q, idx_en_d, tick_q, tick_d, dir_q, dir_d;
   logic [PW-1:0]    pre_q, pre_d;
   logic [2:0]       ctl_q;
   debounce_vec #(.WIDTH(7), .DB_CYCLES(DB_CYCLES)) u_db (
      .clk (clk),
      .rst (rst),
      .din ({mode, en, sw}),
      .db  (db)
   );
   assign db_mode = mode_t'(db[6:5]);
   // dir_q: 0 = counting up, 1 = counting down (ping-pong only)
   always_comb begin
      st       = !db[4] ? ST_OFF : (db_mode == MODE_MANUAL) ? ST_MANUAL : ST_SCAN;
      chg      = db[6:4] != ctl_q;
      step     = st == ST_SCAN && !chg && pre_q == PRE_MAX;
      pre_d    = (st != ST_SCAN || chg || step) ? '0 : pre_q + 1'b1;
      pp_dir   = dir_q ? (idx_q != '0) : (idx_q == IDX_MAX);
      scan_idx = db_mode == MODE_UP   ? idx_q + 1'b1 :
                 db_mode == MODE_DOWN ? idx_q - 1'b1 :
                 dir_q ? ((idx_q == '0) ? 4'd1 : idx_q - 1'b1) :
                         ((idx_q == IDX_MAX) ? IDX_MAX - 1'b1 : idx_q + 1'b1);
      idx_d    = st == ST_MANUAL ? db[3:0] : step ? scan_idx : idx_q;
      dir_d    = (st != ST_SCAN || db_mode != MODE_PINGPONG) ? 1'b0 : step ? pp_dir : dir_q;
      idx_en_d = st != ST_OFF;
      tick_d   = step;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q    <= '0;
         idx_en_q <= 1'b0;
         tick_q   <= 1'b0;
         pre_q    <= '0;
         dir_q    <= 1'b0;
         ctl_q    <= '0;
      end else begin
         idx_q    <= idx_d;
         idx_en_q <= idx_en_d;
         tick_q   <= tick_d;
         pre_q    <= pre_d;
         dir_q    <= dir_d;
         ctl_q    <= db[6:4];
      end
   end
   assign idx    = idx_q;
   assign idx_en = idx_en_q;
   assign tick   = tick_q;
endmodule
